// File: rtl/div_if.sv
// Handshake and operand/result bundle for the iterative divider.
// The requester drives through master; div_unit attaches through slave.
interface div_if;
  logic        start;
  logic        signed_div;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        cancel;
  logic        busy;
  logic        result_valid;
  logic [31:0] lo;
  logic [31:0] hi;

  modport master (
    output start, signed_div, num1, num2, cancel,
    input  busy, result_valid, lo, hi
  );

  modport slave (
    input  start, signed_div, num1, num2, cancel,
    output busy, result_valid, lo, hi
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit DIV/DIVU: restoring shift-subtract, one quotient bit per cycle.
// Optional DIV_ZERO_FAST_EN: a zero divisor bypasses CALC and finishes after one cycle.
module div_unit (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  iter;

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] lo_q;
  logic [31:0] hi_q;

  logic        load;
  logic        commit;
`ifdef DIV_ZERO_FAST_EN
  logic        fast;
  logic [31:0] fast_lo;
`endif

  // Magnitudes of the incoming operands; DIVU passes them through untouched.
  logic [31:0] mag1;
  logic [31:0] mag2;

  always_comb begin
    mag1 = (bus.signed_div && bus.num1[31]) ? (32'd0 - bus.num1) : bus.num1;
    mag2 = (bus.signed_div && bus.num2[31]) ? (32'd0 - bus.num2) : bus.num2;
  end

  // One restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not borrow.
  logic [32:0] shifted;
  logic [32:0] trial;
  logic        qbit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] q_res;
  logic [31:0] r_res;

  always_comb begin
    shifted  = {rem, quo[31]};
    trial    = shifted - {1'b0, dvs};
    qbit     = ~trial[32];
    rem_step = qbit ? trial[31:0] : shifted[31:0];
    quo_step = {quo[30:0], qbit};
    q_res    = neg_q ? (32'd0 - quo_step) : quo_step;
    r_res    = neg_r ? (32'd0 - rem_step) : rem_step;
  end

  // A zero divisor naturally yields all-ones magnitude quotient and the
  // dividend as remainder, so only the fast path needs explicit values.
`ifdef DIV_ZERO_FAST_EN
  always_comb begin
    fast_lo = (bus.signed_div && bus.num1[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
  end
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    commit     = 1'b0;
`ifdef DIV_ZERO_FAST_EN
    fast       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (bus.num2 == 32'd0) begin
            fast       = 1'b1;
            state_next = FINISH;
          end else begin
            state_next = CALC;
          end
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (iter == 5'd31) begin
          commit     = 1'b1;
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Flush wins over everything, including a simultaneous start.
    if (bus.cancel) begin
      state_next = IDLE;
      load       = 1'b0;
      commit     = 1'b0;
`ifdef DIV_ZERO_FAST_EN
      fast       = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      iter  <= 5'd0;
    end else begin
      state <= state_next;
      // The 5-bit counter wraps 31->0 on the final CALC step by itself.
      iter  <= (state == CALC && !bus.cancel) ? iter + 5'd1 : 5'd0;
    end
  end

  // NOTE: the working registers are deliberately not reset; they are always
  // loaded on start before being read, and hi/lo are the only visible state.
  always_ff @(posedge clk) begin
    if (load) begin
      quo   <= mag1;
      rem   <= 32'd0;
      dvs   <= mag2;
      neg_q <= bus.signed_div & (bus.num1[31] ^ bus.num2[31]);
      neg_r <= bus.signed_div & bus.num1[31];
    end else if (state == CALC) begin
      quo   <= quo_step;
      rem   <= rem_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= 32'd0;
      hi_q <= 32'd0;
    end else if (commit) begin
      lo_q <= q_res;
      hi_q <= r_res;
`ifdef DIV_ZERO_FAST_EN
    end else if (fast) begin
      lo_q <= fast_lo;
      hi_q <= bus.num1;
`endif
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = (state == FINISH);
  assign bus.lo           = lo_q;
  assign bus.hi           = hi_q;

endmodule
